// File: rtl/calc_sequencer_pkg.sv
// Shared definitions for the calculator sequencer: FSM state encoding,
// operator encodings and the digit-counter width helper.
package calc_sequencer_pkg;

   typedef enum logic [2:0] {
      S_A    = 3'd0,
      S_OP   = 3'd1,
      S_B    = 3'd2,
      S_EXEC = 3'd3,
      S_RES  = 3'd4,
      S_ERR  = 3'd5
   } state_t;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   function automatic int count_width(input int max_digits);
      return $clog2(max_digits + 1);
   endfunction

endpackage

// File: rtl/calc_sequencer_dec_accum.sv
// Decimal digit accumulator: y = x*10 + digit, built from shifts and adds,
// plus the check that the digit is 0..9 and the operand still has room.
module dec_accum #(
   parameter int WIDTH      = 16,
   parameter int MAX_DIGITS = 4,
   parameter int CNT_W      = 3
) (
   input  logic [WIDTH-1:0] x,
   input  logic [3:0]       digit,
   input  logic [CNT_W-1:0] count,
   output logic [WIDTH-1:0] y,
   output logic             accept
);

   always_comb begin
      y      = (x << 3) + (x << 1) + WIDTH'(digit);
      accept = (digit <= 4'd9) && (count < CNT_W'(MAX_DIGITS));
   end

endmodule

// File: rtl/calc_sequencer.sv
// Calculator control FSM: builds decimal operands from key strobes, issues one
// start/done transaction to the ALU and holds the result or error for display.
module calc_sequencer
   import calc_sequencer_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int MAX_DIGITS = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             is_num,
   input  logic             is_op,
   input  logic             is_eq,
   input  logic [3:0]       num_val,
   input  logic [1:0]       op_val,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [1:0]       alu_op,
   output logic             alu_start,
   input  logic             alu_done,
   input  logic [WIDTH-1:0] alu_res,
   input  logic             alu_ovf,
   output logic [WIDTH-1:0] disp_val,
   output logic             err,
   output logic             busy,
   output state_t           dbg_state
);

   localparam int CNT_W = count_width(MAX_DIGITS);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, disp_q, disp_d;
   logic [1:0]       op_q, op_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             start_q, start_d;

   logic             key_eq, key_op, key_num;
   logic [WIDTH-1:0] acc_x, acc_y;
   logic [CNT_W-1:0] acc_cnt;
   logic             acc_ok;

   // Only one key is acted on per cycle: eq beats op beats num.
   assign key_eq  = is_eq;
   assign key_op  = is_op & ~is_eq;
   assign key_num = is_num & ~is_op & ~is_eq;

   // Fresh operands (from S_OP/S_RES) accumulate from zero with an empty count.
   always_comb begin
      acc_x   = '0;
      acc_cnt = '0;
      if (state_q == S_A) begin
         acc_x   = a_q;
         acc_cnt = cnt_q;
      end else if (state_q == S_B) begin
         acc_x   = b_q;
         acc_cnt = cnt_q;
      end
   end

   dec_accum #(
      .WIDTH      (WIDTH),
      .MAX_DIGITS (MAX_DIGITS),
      .CNT_W      (CNT_W)
   ) u_dec_accum (
      .x      (acc_x),
      .digit  (num_val),
      .count  (acc_cnt),
      .y      (acc_y),
      .accept (acc_ok)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_A;
         a_q     <= '0;
         b_q     <= '0;
         r_q     <= '0;
         disp_q  <= '0;
         op_q    <= OP_ADD;
         cnt_q   <= '0;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         r_q     <= r_d;
         disp_q  <= disp_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         start_q <= start_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      r_d     = r_q;
      disp_d  = disp_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      start_d = 1'b0;
      case (state_q)
         S_A: begin
            if (key_op) begin
               op_d    = op_val;
               state_d = S_OP;
            end else if (key_num && acc_ok) begin
               a_d    = acc_y;
               cnt_d  = cnt_q + CNT_ONE;
               disp_d = acc_y;
            end
         end
         S_OP: begin
            if (key_op) begin
               op_d = op_val;
            end else if (key_num && acc_ok) begin
               b_d     = acc_y;
               cnt_d   = CNT_ONE;
               disp_d  = acc_y;
               state_d = S_B;
            end
         end
         S_B: begin
            if (key_eq) begin
               if (op_q == OP_DIV && b_q == '0) begin
                  disp_d  = '0;
                  state_d = S_ERR;
               end else begin
                  start_d = 1'b1;
                  state_d = S_EXEC;
               end
            end else if (key_num && acc_ok) begin
               b_d    = acc_y;
               cnt_d  = cnt_q + CNT_ONE;
               disp_d = acc_y;
            end
         end
         S_EXEC: begin
            if (alu_done) begin
               if (alu_ovf) begin
                  disp_d  = '0;
                  state_d = S_ERR;
               end else begin
                  disp_d  = alu_res;
                  r_d     = alu_res;
                  state_d = S_RES;
               end
            end
         end
         S_RES: begin
            if (key_op) begin
               a_d     = r_q;
               op_d    = op_val;
               state_d = S_OP;
            end else if (key_num && acc_ok) begin
               a_d     = acc_y;
               b_d     = '0;
               cnt_d   = CNT_ONE;
               disp_d  = acc_y;
               state_d = S_A;
            end
         end
         S_ERR: begin
            // Any key clears the error and is swallowed.
            if (is_num || is_op || is_eq) begin
               a_d     = '0;
               b_d     = '0;
               op_d    = OP_ADD;
               cnt_d   = '0;
               disp_d  = '0;
               state_d = S_A;
            end
         end
         default: state_d = S_A;
      endcase
   end

   assign alu_a     = a_q;
   assign alu_b     = b_q;
   assign alu_op    = op_q;
   assign alu_start = start_q;
   assign disp_val  = disp_q;
   assign err       = (state_q == S_ERR);
   assign busy      = (state_q == S_EXEC);
   assign dbg_state = state_q;

endmodule
